// File: rtl/green_bar_level.sv
// ============================================================================
// Module   : green_bar_level
// Purpose  : Scales a per-frame count to the green bar right edge (T_x) and
//            commits it only after frame_start. Optional macro: PEAK_HOLD_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module green_bar_level #(
  parameter int X_MIN      = 11,
  parameter int X_MAX      = 161,
  parameter int Y_MAX      = 109,
  parameter int CNT_W      = 16,
  parameter int FULL_SCALE = 1000,
  parameter int DECAY_STEP = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [CNT_W-1:0] s_count,
  input  logic             frame_start,
  output logic [10:0]      T_x,
  output logic [9:0]       T_y,
  output logic             busy
);

  localparam int          c_SPAN     = X_MAX - X_MIN + 1;
  localparam int          c_NUM_W    = CNT_W + 8;
  localparam int          c_BIT_W    = $clog2(c_NUM_W + 1);
  localparam logic [10:0] c_TX_EMPTY = 11'(X_MIN - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0]   r_pend;
  logic               r_pend_valid;
  logic [c_NUM_W-1:0] r_num;
  logic [CNT_W-1:0]   r_rem;
  logic [c_BIT_W-1:0] r_bit;

  logic               w_start;
  logic               w_accept;
  logic               w_last;
  logic               w_ge;
  logic [CNT_W-1:0]   w_clamp;
  logic [c_NUM_W-1:0] w_prod;
  logic [CNT_W:0]     w_trial;
  logic [10:0]        w_tx_new;
  logic [10:0]        w_tx_commit;

  assign s_ready  = !r_pend_valid;
  assign busy     = (r_state != S_IDLE);
  assign T_y      = 10'(Y_MAX);

  assign w_start  = (r_state == S_IDLE) && frame_start && r_pend_valid;
  assign w_accept = s_valid && !r_pend_valid;
  assign w_clamp  = (r_pend > CNT_W'(FULL_SCALE)) ? CNT_W'(FULL_SCALE) : r_pend;
  assign w_prod   = c_NUM_W'(w_clamp) * c_NUM_W'(c_SPAN);

  // Restoring division: the numerator shifts out its MSB into the partial
  // remainder while quotient bits shift in at the LSB, so r_num ends as q.
  assign w_trial  = {r_rem, r_num[c_NUM_W-1]};
  assign w_ge     = (w_trial >= (CNT_W + 1)'(FULL_SCALE));
  assign w_last   = (r_bit == c_BIT_W'(c_NUM_W));
  assign w_tx_new = c_TX_EMPTY + 11'(r_num);

`ifdef PEAK_HOLD_EN
  localparam logic [10:0] c_TX_DEC_MIN = 11'(X_MIN - 1 + DECAY_STEP);
  logic [10:0] w_tx_dec;
  assign w_tx_dec    = (T_x >= c_TX_DEC_MIN) ? (T_x - 11'(DECAY_STEP)) : c_TX_EMPTY;
  assign w_tx_commit = (w_tx_new > w_tx_dec) ? w_tx_new : w_tx_dec;
`else
  assign w_tx_commit = w_tx_new;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (w_start) w_next = S_CALC;
      S_CALC:   if (w_last)  w_next = S_COMMIT;
      S_COMMIT: w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend       <= '0;
      r_pend_valid <= 1'b0;
      r_num        <= '0;
      r_rem        <= '0;
      r_bit        <= '0;
      T_x          <= c_TX_EMPTY;
    end else begin
      if (w_start) begin
        r_pend_valid <= 1'b0;
      end else if (w_accept) begin
        r_pend       <= s_count;
        r_pend_valid <= 1'b1;
      end

      unique case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_num <= w_prod;
            r_rem <= '0;
            r_bit <= '0;
          end
`ifdef PEAK_HOLD_EN
          else if (frame_start) begin
            T_x <= w_tx_dec;
          end
`endif
        end
        S_CALC: begin
          // One extra CALC cycle after the last bit aligns the commit latency.
          if (!w_last) begin
            r_rem <= w_ge ? CNT_W'(w_trial - (CNT_W + 1)'(FULL_SCALE)) : CNT_W'(w_trial);
            r_num <= {r_num[c_NUM_W-2:0], w_ge};
            r_bit <= r_bit + 1'b1;
          end
        end
        S_COMMIT: T_x <= w_tx_commit;
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_green_bar_level.sv
// ============================================================================
// Module   : tb_green_bar_level
// Purpose  : Randomized scoreboard bench for green_bar_level.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_green_bar_level;

  localparam int X_MIN      = 11;
  localparam int X_MAX      = 161;
  localparam int Y_MAX      = 109;
  localparam int CNT_W      = 16;
  localparam int FULL_SCALE = 1000;
  localparam int DECAY_STEP = 8;
  localparam int SPAN       = X_MAX - X_MIN + 1;
  localparam int LAT        = CNT_W + 8 + 2;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             s_valid = 1'b0;
  logic [CNT_W-1:0] s_count = '0;
  logic             frame_start = 1'b0;
  logic             s_ready;
  logic [10:0]      T_x;
  logic [9:0]       T_y;
  logic             busy;

  always #5 clk = ~clk;

  green_bar_level #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .CNT_W(CNT_W), .FULL_SCALE(FULL_SCALE), .DECAY_STEP(DECAY_STEP)
  ) dut (
    .clk(clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready),
    .s_count(s_count), .frame_start(frame_start), .T_x(T_x), .T_y(T_y), .busy(busy)
  );

  int n_vec = 0;
  int n_bad = 0;
  int exp_q[$];
  int model_tx = X_MIN - 1;
  bit have_pend = 1'b0;
  int pend_val = 0;
  int busy_cnt = 0;
  bit prev_busy = 1'b0;

  function automatic int scale(input int c);
    int cl;
    cl = (c > FULL_SCALE) ? FULL_SCALE : c;
    return X_MIN - 1 + (cl * SPAN) / FULL_SCALE;
  endfunction

  function automatic int decayed(input int t);
    return (t - DECAY_STEP < X_MIN - 1) ? X_MIN - 1 : t - DECAY_STEP;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Monitor: pops the scoreboard on each commit (busy falling) and
  // otherwise requires T_x to hold the last committed value.
  always @(negedge clk) begin
    #1;
    if (!reset) begin
      prev_busy = 1'b0;
      busy_cnt  = 0;
    end else begin
      if (prev_busy && !busy) begin
        check("commit_latency", busy_cnt, LAT);
        if (exp_q.size() == 0) begin
          fail_now("unexpected_commit");
        end else begin
          model_tx = exp_q.pop_front();
          check("commit_tx", int'(T_x), model_tx);
        end
        busy_cnt = 0;
      end else begin
        if (busy) busy_cnt++;
        check("tx_hold", int'(T_x), model_tx);
      end
      prev_busy = busy;
    end
  end

  task automatic send(input int v);
    int n;
    n = 0;
    @(negedge clk);
    s_valid = 1'b1;
    s_count = CNT_W'(v);
    while (!s_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) begin
      fail_now("send_timeout");
      s_valid = 1'b0;
    end else begin
      @(negedge clk);
      s_valid   = 1'b0;
      have_pend = 1'b1;
      pend_val  = v;
    end
  endtask

  // idle_known: the bench knows the DUT is idle, so the frame takes effect.
  task automatic pulse_frame(input bit idle_known);
    bit do_decay;
    do_decay = 1'b0;
    @(negedge clk);
    frame_start = 1'b1;
    if (idle_known) begin
      if (have_pend) begin
`ifdef PEAK_HOLD_EN
        exp_q.push_back((scale(pend_val) > decayed(model_tx)) ? scale(pend_val) : decayed(model_tx));
`else
        exp_q.push_back(scale(pend_val));
`endif
        have_pend = 1'b0;
      end else begin
`ifdef PEAK_HOLD_EN
        do_decay = 1'b1;
`endif
      end
    end
    @(negedge clk);
    frame_start = 1'b0;
    if (do_decay) model_tx = decayed(model_tx);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (busy) fail_now("idle_timeout");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[3];
    int v;

    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_tx", int'(T_x), 10);
    check("reset_ty", int'(T_y), 109);
    check("reset_ready", int'(s_ready), 1);
    check("reset_busy", int'(busy), 0);

    // Scale: 500 -> 85
    send(500);
    check("ready_after_accept", int'(s_ready), 0);
    pulse_frame(1'b1);
    check("ready_after_frame", int'(s_ready), 1);
    wait_idle();
    @(negedge clk);
    check("scale_500", int'(T_x), 85);

    // Bounds
    vals[0] = 1000; vals[1] = 65535; vals[2] = 0;
    foreach (vals[i]) begin
      send(vals[i]);
      pulse_frame(1'b1);
      wait_idle();
    end

    // Backpressure: second sample held until the cycle after frame_start
    send(300);
    @(negedge clk);
    s_valid = 1'b1;
    s_count = CNT_W'(777);
    check("bp_stall", int'(s_ready), 0);
    @(negedge clk);
    check("bp_still_stall", int'(s_ready), 0);
    frame_start = 1'b1;
    exp_q.push_back(scale(300));
    have_pend = 1'b0;
    @(negedge clk);
    frame_start = 1'b0;
    check("bp_ready_after_frame", int'(s_ready), 1);
    @(negedge clk);
    s_valid   = 1'b0;
    have_pend = 1'b1;
    pend_val  = 777;
    check("bp_second_held", int'(s_ready), 0);
    wait_idle();
    pulse_frame(1'b1);
    wait_idle();

    // frame_start during CALC is ignored; a sample accepted mid-CALC waits
    send(640);
    pulse_frame(1'b1);
    repeat (4) @(negedge clk);
    send(222);
    pulse_frame(1'b0);
    wait_idle();
    check("busy_pend_kept", int'(s_ready), 0);
    pulse_frame(1'b1);
    wait_idle();

    // Reset mid-CALC
    send(900);
    pulse_frame(1'b1);
    repeat (6) @(negedge clk);
    exp_q.delete();
    model_tx  = X_MIN - 1;
    have_pend = 1'b0;
    reset = 1'b0;
    #1;
    check("rst_mid_tx", int'(T_x), 10);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_ready", int'(s_ready), 1);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);

    // Randomized frames, some without a sample
    repeat (30) begin
      if ($urandom_range(0, 3) != 0) begin
        if ($urandom_range(0, 1) == 0) v = int'($urandom_range(0, 1200));
        else                            v = int'($urandom_range(0, 65535));
        send(v);
      end
      pulse_frame(1'b1);
      wait_idle();
    end

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
